calc_operand_select: RTL

Clocked, parametrised operand/result selector for the calculator's VGA front end. Tracks the entry phase (first operand, second operand, result) from mouse-button clicks and the key code under the pointer, and latches the chosen operator. Drives a registered sign-magnitude value to the digit renderer. Replaces the combinational, latch-based selector: button edges are detected synchronously, clear works from any phase, and the output tracks the live source.

---
 rtl/calc_operand_select.sv | 97 +++++++++
 1 files changed

// File: rtl/calc_operand_select.sv
// calc_operand_select: entry-phase FSM and registered sign-magnitude operand/result selector
// Optional: OPSEL_BTN_SYNC_EN routes btnm through a 2-flop synchronizer before edge detection.
module calc_operand_select #(
    parameter int WIDTH    = 32,
    parameter int CODE_W   = 5,
    parameter int OP_MIN   = 10,
    parameter int OP_MAX   = 14,
    parameter int EQ_CODE  = 15,
    parameter int CLR_CODE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  num_a,
    input  logic [WIDTH-1:0]  num_b,
    input  logic [WIDTH-1:0]  result,
    input  logic [CODE_W-1:0] code,
    input  logic              btnm,
    output logic [WIDTH:0]    num_out,
    output logic [1:0]        phase,
    output logic [CODE_W-1:0] op_code,
    output logic              phase_chg
);
    typedef enum logic [1:0] {ENTER_A = 2'b00, ENTER_B = 2'b01, SHOW_RES = 2'b10} state_t;

    localparam logic [CODE_W-1:0] op_lo  = CODE_W'(OP_MIN);
    localparam logic [CODE_W-1:0] op_hi  = CODE_W'(OP_MAX);
    localparam logic [CODE_W-1:0] eq_cd  = CODE_W'(EQ_CODE);
    localparam logic [CODE_W-1:0] clr_cd = CODE_W'(CLR_CODE);

    state_t state, state_q;
    logic btn_c, btn_q, armed, click, is_op;
    logic [WIDTH-1:0] src, mag;

`ifdef OPSEL_BTN_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], btnm};
    assign btn_c = sync[1];
`else
    assign btn_c = btnm;
`endif

    // armed stays low until the button is seen released, so a press held through reset is ignored
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            btn_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn_c;
            armed <= armed | ~btn_c;
        end

    assign click = btn_c & ~btn_q & armed;
    assign is_op = (code >= op_lo) && (code <= op_hi);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= ENTER_A;
            op_code <= '0;
        end else begin
            case (state)
                ENTER_A:  if (click && code == clr_cd) op_code <= '0;
                          else if (click && is_op) begin
                              state   <= ENTER_B;
                              op_code <= code;
                          end
                ENTER_B:  if (click && code == clr_cd) begin
                              state   <= ENTER_A;
                              op_code <= '0;
                          end else if (click && code == eq_cd) state <= SHOW_RES;
                SHOW_RES: if (click && code == clr_cd) begin
                              state   <= ENTER_A;
                              op_code <= '0;
                          end else if (click && is_op) begin
                              state   <= ENTER_B;
                              op_code <= code;
                          end
                default:  state <= ENTER_A;
            endcase
        end

    assign phase = state;
    assign src   = state == ENTER_A ? num_a : state == ENTER_B ? num_b : result;
    assign mag   = src[WIDTH-1] ? -src : src;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= ENTER_A;
            phase_chg <= 1'b0;
            num_out   <= '0;
        end else begin
            state_q   <= state;
            phase_chg <= state != state_q;
            num_out   <= {src[WIDTH-1], mag};
        end
endmodule
